// File: rtl/decode_writeback_if.sv
// Decode/writeback bus for the Y86-64 SEQ register-file front end.
// The master drives instruction fields and write data; the slave returns operands and status.
interface decode_writeback_if;
    logic        dec_en;
    logic [3:0]  d_icode;
    logic [3:0]  d_rA;
    logic [3:0]  d_rB;
    logic        wb_en;
    logic [3:0]  w_icode;
    logic [3:0]  w_rA;
    logic [3:0]  w_rB;
    logic        w_Cnd;
    logic [63:0] w_valE;
    logic [63:0] w_valM;
    logic [63:0] valA;
    logic [63:0] valB;
    logic        halted;
    logic        instr_err;

    modport master (
        output dec_en, d_icode, d_rA, d_rB,
        output wb_en, w_icode, w_rA, w_rB, w_Cnd, w_valE, w_valM,
        input  valA, valB, halted, instr_err
    );

    modport slave (
        input  dec_en, d_icode, d_rA, d_rB,
        input  wb_en, w_icode, w_rA, w_rB, w_Cnd, w_valE, w_valM,
        output valA, valB, halted, instr_err
    );
endinterface

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/writeback: 15-entry register file, registered operands, sticky halt status.
// Optional macro DECODE_BYPASS_EN forwards same-edge write data into the captured operands.
module decode_writeback #(
    parameter logic [3:0] RSP_ID   = 4'h4,
    parameter logic [3:0] RNONE_ID = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    decode_writeback_if.slave bus
);
    localparam logic [3:0] I_HALT  = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    logic [63:0] regs [0:14];
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        halt_now;
    logic        commit;
    logic [63:0] rd_a;
    logic [63:0] rd_b;
    logic [63:0] op_a;
    logic [63:0] op_b;

    always_comb begin
        src_a = RNONE_ID;
        src_b = RNONE_ID;
        case (bus.d_icode)
            I_CMOV, I_RMMOV, I_OPQ, I_PUSH: src_a = bus.d_rA;
            I_POP, I_RET:                   src_a = RSP_ID;
            default:                        src_a = RNONE_ID;
        endcase
        case (bus.d_icode)
            I_OPQ, I_RMMOV, I_MRMOV:        src_b = bus.d_rB;
            I_PUSH, I_POP, I_CALL, I_RET:   src_b = RSP_ID;
            default:                        src_b = RNONE_ID;
        endcase
    end

    always_comb begin
        dst_e = RNONE_ID;
        dst_m = RNONE_ID;
        case (bus.w_icode)
            I_CMOV:                         dst_e = bus.w_Cnd ? bus.w_rB : RNONE_ID;
            I_IRMOV, I_OPQ:                 dst_e = bus.w_rB;
            I_PUSH, I_POP, I_CALL, I_RET:   dst_e = RSP_ID;
            default:                        dst_e = RNONE_ID;
        endcase
        case (bus.w_icode)
            I_MRMOV, I_POP:                 dst_m = bus.w_rA;
            default:                        dst_m = RNONE_ID;
        endcase
    end

    // The commit that raises halted writes nothing, and nothing commits afterwards.
    assign halt_now = (bus.w_icode == I_HALT) || (bus.w_icode > I_POP);
    assign commit   = bus.wb_en && !bus.halted && !halt_now;

    always_comb begin
        rd_a = (src_a == RNONE_ID) ? 64'h0 : regs[src_a];
        rd_b = (src_b == RNONE_ID) ? 64'h0 : regs[src_b];
`ifdef DECODE_BYPASS_EN
        if (commit && dst_m != RNONE_ID && src_a == dst_m)
            op_a = bus.w_valM;
        else if (commit && dst_e != RNONE_ID && src_a == dst_e)
            op_a = bus.w_valE;
        else
            op_a = rd_a;
        if (commit && dst_m != RNONE_ID && src_b == dst_m)
            op_b = bus.w_valM;
        else if (commit && dst_e != RNONE_ID && src_b == dst_e)
            op_b = bus.w_valE;
        else
            op_b = rd_b;
`else
        op_a = rd_a;
        op_b = rd_b;
`endif
    end

    // Decode capture stage
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valA <= 64'h0;
            bus.valB <= 64'h0;
        end else if (bus.dec_en) begin
            bus.valA <= op_a;
            bus.valB <= op_b;
        end
    end

    // Writeback stage: valM is written last so it wins when dstE == dstM
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) regs[i] <= 64'h0;
        end else if (commit) begin
            if (dst_e != RNONE_ID) regs[dst_e] <= bus.w_valE;
            if (dst_m != RNONE_ID) regs[dst_m] <= bus.w_valM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.halted    <= 1'b0;
            bus.instr_err <= 1'b0;
        end else if (bus.wb_en && !bus.halted) begin
            if (halt_now)              bus.halted    <= 1'b1;
            if (bus.w_icode > I_POP)   bus.instr_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: directed plan steps, then random traffic against a transaction model.
module tb_decode_writeback;
    logic clk = 1'b0;
    logic rst;
    decode_writeback_if bus();

    decode_writeback dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] mr [0:14];
    logic        m_halted;
    logic        m_err;
    logic [63:0] exp_a;
    logic [63:0] exp_b;

    function automatic bit in_set(input logic [3:0] v, input logic [15:0] mask);
        return mask[v];
    endfunction

    // Operand and destination rules, expressed as icode membership sets
    function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
        if (in_set(ic, 16'b0000_0100_0101_0100)) return ra;      // 2,4,6,A
        if (in_set(ic, 16'b0000_1010_0000_0000)) return 4'h4;    // 9,B
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
        if (in_set(ic, 16'b0000_0000_0111_0000)) return rb;      // 4,5,6
        if (in_set(ic, 16'b0000_1111_0000_0000)) return 4'h4;    // 8,9,A,B
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
        if (ic == 4'h2) return c ? rb : 4'hF;
        if (ic == 4'h3 || ic == 4'h6) return rb;
        if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
        return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] s, input bit cm,
                                           input logic [3:0] de, input logic [3:0] dm,
                                           input logic [63:0] ve, input logic [63:0] vm);
        if (s == 4'hF) return 64'h0;
`ifdef DECODE_BYPASS_EN
        if (cm && s == dm) return vm;
        if (cm && s == de) return ve;
`endif
        return mr[s];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic de, input logic [3:0] di, input logic [3:0] dra,
                        input logic [3:0] drb, input logic we, input logic [3:0] wi,
                        input logic [3:0] wra, input logic [3:0] wrb, input logic wc,
                        input logic [63:0] ve, input logic [63:0] vm);
        logic [3:0] sa, sb, dse, dsm;
        logic [63:0] na, nb;
        bit cm;
        rst = r;
        bus.dec_en = de; bus.d_icode = di; bus.d_rA = dra; bus.d_rB = drb;
        bus.wb_en = we; bus.w_icode = wi; bus.w_rA = wra; bus.w_rB = wrb;
        bus.w_Cnd = wc; bus.w_valE = ve; bus.w_valM = vm;
        sa  = m_src_a(di, dra);
        sb  = m_src_b(di, drb);
        dse = m_dst_e(wi, wrb, wc);
        dsm = m_dst_m(wi, wra);
        cm  = we && !m_halted && wi != 4'h1 && wi <= 4'hB;
        na  = m_read(sa, cm, dse, dsm, ve, vm);
        nb  = m_read(sb, cm, dse, dsm, ve, vm);
        if (r) begin
            foreach (mr[i]) mr[i] = 64'h0;
            m_halted = 1'b0; m_err = 1'b0; exp_a = 64'h0; exp_b = 64'h0;
        end else begin
            if (de) begin exp_a = na; exp_b = nb; end
            if (cm) begin
                if (dse != 4'hF) mr[dse] = ve;
                if (dsm != 4'hF) mr[dsm] = vm;
            end
            if (we && !m_halted) begin
                if (wi == 4'h1) m_halted = 1'b1;
                if (wi > 4'hB) begin m_halted = 1'b1; m_err = 1'b1; end
            end
        end
        @(posedge clk);
        #1;
        check("valA", bus.valA, exp_a);
        check("valB", bus.valB, exp_b);
        check("halted", {63'h0, bus.halted}, {63'h0, m_halted});
        check("instr_err", {63'h0, bus.instr_err}, {63'h0, m_err});
    endtask

    task automatic idle_wb(input logic [3:0] wi, input logic [3:0] wra, input logic [3:0] wrb,
                           input logic wc, input logic [63:0] ve, input logic [63:0] vm);
        step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, wi, wra, wrb, wc, ve, vm);
    endtask

    task automatic dec_only(input logic [3:0] di, input logic [3:0] dra, input logic [3:0] drb);
        step(1'b0, 1'b1, di, dra, drb, 1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    endtask

    initial begin
        logic [3:0] ic_w, ic_d;
        foreach (mr[i]) mr[i] = 64'h0;
        m_halted = 1'b0; m_err = 1'b0; exp_a = 64'h0; exp_b = 64'h0;
        rst = 1'b1;
        bus.dec_en = 1'b0; bus.d_icode = 4'h0; bus.d_rA = 4'h0; bus.d_rB = 4'h0;
        bus.wb_en = 1'b0; bus.w_icode = 4'h0; bus.w_rA = 4'h0; bus.w_rB = 4'h0;
        bus.w_Cnd = 1'b0; bus.w_valE = 64'h0; bus.w_valM = 64'h0;

        // Reset then decode OPQ r0,r3
        step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0);
        dec_only(4'h6, 4'h0, 4'h3);
        check("tp_reset_valA", bus.valA, 64'h0);

        // IRMOV R2 then read it through both operands
        idle_wb(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0);
        dec_only(4'h6, 4'h2, 4'h2);
        check("tp_irmov_valA", bus.valA, 64'h1234);
        check("tp_irmov_valB", bus.valB, 64'h1234);

        // Conditional move, not taken then taken
        idle_wb(4'h2, 4'hF, 4'h5, 1'b0, 64'hAA, 64'h0);
        dec_only(4'h6, 4'h5, 4'h5);
        check("tp_cmov_nt", bus.valA, 64'h0);
        idle_wb(4'h2, 4'hF, 4'h5, 1'b1, 64'hAA, 64'h0);
        dec_only(4'h6, 4'h5, 4'h5);
        check("tp_cmov_t", bus.valA, 64'hAA);

        // popq %rsp: valM wins over valE
        idle_wb(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h77);
        dec_only(4'hA, 4'h4, 4'hF);
        check("tp_pop_rsp", bus.valA, 64'h77);

        // HALT blocks later writes
        idle_wb(4'h3, 4'hF, 4'h1, 1'b0, 64'h33, 64'h0);
        idle_wb(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        idle_wb(4'h3, 4'hF, 4'h1, 1'b0, 64'h5, 64'h0);
        dec_only(4'h6, 4'h1, 4'h1);
        check("tp_halt_r1", bus.valA, 64'h33);
        check("tp_halt_flag", {63'h0, bus.halted}, 64'h1);
        check("tp_halt_err", {63'h0, bus.instr_err}, 64'h0);

        // Invalid icode after reset
        step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0);
        idle_wb(4'hC, 4'h3, 4'h3, 1'b1, 64'hDEAD, 64'hBEEF);
        check("tp_inv_err", {63'h0, bus.instr_err}, 64'h1);

        // Same-edge read/write of R7
        step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0);
        idle_wb(4'h3, 4'hF, 4'h7, 1'b0, 64'h11, 64'h0);
        step(1'b0, 1'b1, 4'h6, 4'h7, 4'hF, 1'b1, 4'h3, 4'hF, 4'h7, 1'b0, 64'h99, 64'h0);
`ifdef DECODE_BYPASS_EN
        check("tp_same_edge", bus.valA, 64'h99);
`else
        check("tp_same_edge", bus.valA, 64'h11);
`endif
        step(1'b1, 1'b1, 4'h6, 4'h7, 4'h7, 1'b1, 4'h3, 4'hF, 4'h7, 1'b0, 64'h55, 64'h0);
        check("tp_rst_over", bus.valA, 64'h0);
        dec_only(4'h6, 4'h7, 4'h7);
        check("tp_rst_r7", bus.valB, 64'h0);

        // Random traffic; icodes mostly valid so the file keeps changing
        for (int n = 0; n < 600; n++) begin
            ic_w = ($urandom_range(0, 31) < 30) ? 4'($urandom_range(2, 11)) : 4'($urandom_range(0, 15));
            ic_d = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 60) == 0) || (m_halted && $urandom_range(0, 5) == 0),
                 1'($urandom), ic_d, 4'($urandom), 4'($urandom),
                 1'($urandom), ic_w, 4'($urandom), 4'($urandom), 1'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
